cons_seq: RTL and testbench
===========================

# cons_seq

Console command sequencer between the console bus register and the CPU console-status logic. It accepts one command at a time (RUN, HALT, CONT, EXEC, STEP) from the console bus. It converts the command into the correct `csl*` switch request, held until a `clken` cycle samples it. It then watches the `cpu*` status flags until the microcode has completed the command, and returns a completion handshake with an error code.

## Interface
- `TIMEOUT`, 1024: WAIT-state clock cycles before a command is abandoned. Must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `clken` in 1: CPU clock enable; the console-status logic only samples switches when this is high.
- `cmdREQ` in 1: command request; sampled only in IDLE.
- `cmdCODE` in 3: 0 NOP, 1 RUN, 2 HALT, 3 CONT, 4 EXEC, 5 STEP, 6–7 illegal.
- `cmdBUSY` out 1: command accepted and not yet acknowledged.
- `cmdACK` out 1: one-cycle completion pulse.
- `cmdERR` out 2: 00 OK, 01 ILLEGAL, 10 TIMEOUT. Valid with `cmdACK`; held until next accept.
- `cpuRUN`, `cpuHALT`, `cpuCONT`, `cpuEXEC` in 1 each: CPU status flags.
- `cslRUN`, `cslHALT`, `cslCONT`, `cslEXEC` out 1 each: console switch requests.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, `cmdREQ`=1: latch `cmdCODE`, clear the seen flag and the timer, set `cmdBUSY`. Then check preconditions against the current `cpu*` values:
  - NOP: go to DONE, OK.
  - Code 6/7: go to DONE, ILLEGAL.
  - CONT/EXEC with `cpuHALT`=0: DONE, ILLEGAL.
  - STEP with `cpuHALT`=0 or `cpuRUN`=1: DONE, ILLEGAL.
  - Otherwise: go to ISSUE.
- ISSUE drives exactly one switch:
  - RUN → `cslRUN`; HALT → `cslHALT`; CONT → `cslCONT`; EXEC → `cslEXEC`; STEP → `cslCONT`.
  - The switch is held until a cycle with `clken`=1. It drops on the following edge, when the state moves to WAIT.
- WAIT completion conditions:
  - RUN: `cpuRUN`=1.
  - HALT: `cpuRUN`=0 and `cpuHALT`=1.
  - CONT: `cpuCONT` has been seen at 1, and is now 0.
  - EXEC: `cpuEXEC` has been seen at 1, and is now 0.
  - STEP: `cpuCONT` has been seen at 1, and now `cpuCONT`=0 and `cpuHALT`=1.
- The seen flag is set in any WAIT cycle where the monitored flag is 1. It is evaluated combinationally with the current cycle, so set-and-clear in consecutive cycles completes.
- On completion: go to DONE with OK.
- DONE: `cmdACK`=1 for one cycle, `cmdBUSY` drops on the same edge, return to IDLE.
- `cmdREQ` in ISSUE, WAIT or DONE is ignored; it is not queued. The requester re-asserts it after `cmdACK`.
- Boundary conditions:
  - `clken` held low in ISSUE: the switch stays asserted indefinitely. The timer does not run in ISSUE.
  - Completion and timeout in the same cycle: completion wins, OK.
  - `cmdCODE` changing after accept has no effect.
  - `rst` asserted mid-command: immediate return to IDLE, all outputs 0. No partial switch pulse survives.
- Reset values: state IDLE; `cmdBUSY`, `cmdACK` and all `csl*` = 0; `cmdERR` = 00.

## Timing
- With `clken` always 1, the request is seen in cycle 0:
  - RUN or HALT: ISSUE in cycle 1 (switch high), WAIT in cycle 2 (status already updated), `cmdACK` high in cycle 3.
  - NOP or ILLEGAL: `cmdACK` high in cycle 2.
- A switch output is high for at least 1 cycle. It is never high outside ISSUE, and at most one `csl*` is high at a time.
- TIMEOUT: the timer counts clock cycles in WAIT. If it reaches `TIMEOUT` without completion, the block goes to DONE with error 10.

## Configuration
- `CONS_SEQ_TIMEOUT_EN` defined: the WAIT timer and the TIMEOUT error code are compiled in.
- Undefined: no timer. WAIT lasts until completion or reset, `cmdERR` is never 10, and `TIMEOUT` is unused.

## Structure
- Shared package `cons_seq_pkg`:
  - command-code constants;
  - error-code constants;
  - state enum.
- Sub-module `cons_seq_timer`: a loadable down-counter of width $clog2(TIMEOUT+1) with `clr`, `en` and `expired`. It is instantiated only under `CONS_SEQ_TIMEOUT_EN`.

## Test plan
- RUN with `clken`=1 and the CPU model in reset state → `cslRUN` high for exactly 1 cycle, `cmdACK` in cycle 3, `cmdERR`=00.
- CONT issued while `cpuHALT`=0 → no `csl*` activity, `cmdACK` in cycle 2, `cmdERR`=01.
- EXEC with `clken` high 1 in 4 cycles → `cslEXEC` held until the first `clken` cycle. The model sets `cpuEXEC` and clears it 5 cycles later; `cmdACK` follows the clear, `cmdERR`=00.
- HALT with a model that never sets `cpuHALT`, `TIMEOUT`=16, macro defined → `cmdACK` 16 WAIT cycles later, `cmdERR`=10. With the macro undefined, `cmdBUSY` stays high until `rst`.
- STEP from halted; the model pulses `cpuCONT` for 1 cycle, drops `cpuHALT` for 3 cycles, then re-sets it → `cmdACK` only after `cpuHALT` returns to 1, `cmdERR`=00. A second `cmdREQ` while busy is ignored.
- `rst` asserted during ISSUE → `cslCONT`, `cmdBUSY` and `cmdACK` go to 0 immediately; the next command is accepted normally after release.

Source files
------------

// File: rtl/cons_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cons_seq_pkg
// Description : Shared command codes, error codes, sequencer states and the
//               command precondition check for the console command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cons_seq_pkg;

  localparam logic [2:0] c_CMD_NOP  = 3'd0;
  localparam logic [2:0] c_CMD_RUN  = 3'd1;
  localparam logic [2:0] c_CMD_HALT = 3'd2;
  localparam logic [2:0] c_CMD_CONT = 3'd3;
  localparam logic [2:0] c_CMD_EXEC = 3'd4;
  localparam logic [2:0] c_CMD_STEP = 3'd5;

  localparam logic [1:0] c_ERR_OK      = 2'b00;
  localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns {reject, errorCode}. A rejected command never drives a switch.
  function automatic logic [2:0] precheck(input logic [2:0] code,
                                          input logic       cpuRun,
                                          input logic       cpuHalt);
    logic [2:0] res;
    res = {1'b0, c_ERR_OK};
    case (code)
      c_CMD_NOP:              res = {1'b1, c_ERR_OK};
      c_CMD_RUN, c_CMD_HALT:  res = {1'b0, c_ERR_OK};
      c_CMD_CONT, c_CMD_EXEC: if (!cpuHalt) res = {1'b1, c_ERR_ILLEGAL};
      c_CMD_STEP:             if (!cpuHalt || cpuRun) res = {1'b1, c_ERR_ILLEGAL};
      default:                res = {1'b1, c_ERR_ILLEGAL};
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cons_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : cons_seq_timer
// Description : Loadable down-counter for the WAIT-state timeout. clr loads
//               TIMEOUT, en counts down, expired flags the last counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cons_seq_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // Load on clear, otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= W'(TIMEOUT);
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // The TIMEOUT-th enabled cycle is the one that sees a count of 1.
  assign expired = en && (r_count <= W'(1));

endmodule
`default_nettype wire

// File: rtl/cons_seq.sv
`default_nettype none
// ============================================================================
// Module      : cons_seq
// Description : Console command sequencer. Accepts one console command,
//               raises the matching csl* switch until a clken cycle samples
//               it, waits for the CPU status flags to show completion, then
//               acknowledges with an error code.
//               Build option: CONS_SEQ_TIMEOUT_EN adds the WAIT timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cons_seq #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       cmdREQ,
  input  logic [2:0] cmdCODE,
  output logic       cmdBUSY,
  output logic       cmdACK,
  output logic [1:0] cmdERR,
  input  logic       cpuRUN,
  input  logic       cpuHALT,
  input  logic       cpuCONT,
  input  logic       cpuEXEC,
  output logic       cslRUN,
  output logic       cslHALT,
  output logic       cslCONT,
  output logic       cslEXEC
);

  import cons_seq_pkg::*;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_code;
  logic       r_reject;
  logic [1:0] r_rejErr;
  logic       r_seen;

  logic       w_accept;
  logic [2:0] w_check;
  logic       w_flag;
  logic       w_seenNow;
  logic       w_complete;
  logic       w_expired;
  logic       w_timerEn;

  logic [2:0] w_codeNext;
  logic       w_rejectNext;
  logic       w_drive;
  logic       w_cslRun, w_cslHalt, w_cslCont, w_cslExec;
  logic       w_busy, w_ack;
  logic [1:0] w_err;

  assign w_accept  = (r_state == ST_IDLE) && cmdREQ;
  assign w_check   = precheck(cmdCODE, cpuRUN, cpuHALT);
  assign w_timerEn = (r_state == ST_WAIT);

  // EXEC watches cpuEXEC; CONT and STEP watch cpuCONT.
  assign w_flag    = (r_code == c_CMD_EXEC) ? cpuEXEC : cpuCONT;
  // Include the current cycle so a one-cycle pulse followed by a clear completes.
  assign w_seenNow = r_seen || w_flag;

  // Completion test for the latched command, evaluated in WAIT.
  always_comb begin
    w_complete = 1'b0;
    case (r_code)
      c_CMD_RUN:  w_complete = cpuRUN;
      c_CMD_HALT: w_complete = !cpuRUN && cpuHALT;
      c_CMD_CONT: w_complete = w_seenNow && !cpuCONT;
      c_CMD_EXEC: w_complete = w_seenNow && !cpuEXEC;
      c_CMD_STEP: w_complete = w_seenNow && !cpuCONT && cpuHALT;
      default:    w_complete = 1'b0;
    endcase
  end

`ifdef CONS_SEQ_TIMEOUT_EN
  cons_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_accept),
    .en      (w_timerEn),
    .expired (w_expired)
  );
`else
  // No timer in this build: WAIT never expires. The term is constant 0.
  assign w_expired = w_timerEn && (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nextState;
  end

  // Latch the command and its precheck on accept; track the seen flag in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code   <= c_CMD_NOP;
      r_reject <= 1'b0;
      r_rejErr <= c_ERR_OK;
      r_seen   <= 1'b0;
    end else if (w_accept) begin
      r_code   <= cmdCODE;
      r_reject <= w_check[2];
      r_rejErr <= w_check[1:0];
      r_seen   <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_flag) begin
      r_seen   <= 1'b1;
    end
  end

  // Next-state logic. Rejected commands pass through ISSUE without a switch
  // so that NOP/illegal acknowledges arrive at a fixed latency.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (cmdREQ) w_nextState = ST_ISSUE;
      ST_ISSUE: begin
        if (r_reject)   w_nextState = ST_DONE;
        else if (clken) w_nextState = ST_WAIT;
      end
      ST_WAIT:  if (w_complete || w_expired) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every output comes from a register.
  always_comb begin
    w_codeNext   = w_accept ? cmdCODE : r_code;
    w_rejectNext = w_accept ? w_check[2] : r_reject;
    w_drive      = (w_nextState == ST_ISSUE) && !w_rejectNext;
    w_cslRun     = w_drive && (w_codeNext == c_CMD_RUN);
    w_cslHalt    = w_drive && (w_codeNext == c_CMD_HALT);
    w_cslCont    = w_drive && ((w_codeNext == c_CMD_CONT) || (w_codeNext == c_CMD_STEP));
    w_cslExec    = w_drive && (w_codeNext == c_CMD_EXEC);
    w_busy       = (w_nextState != ST_IDLE);
    w_ack        = (w_nextState == ST_DONE);
    w_err        = cmdERR;
    if (w_accept) begin
      w_err = c_ERR_OK;
    end else if ((r_state == ST_ISSUE) && (w_nextState == ST_DONE)) begin
      w_err = r_rejErr;
    end else if ((r_state == ST_WAIT) && (w_nextState == ST_DONE)) begin
      // Completion wins over a timeout in the same cycle.
      w_err = w_complete ? c_ERR_OK : c_ERR_TIMEOUT;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmdBUSY <= 1'b0;
      cmdACK  <= 1'b0;
      cmdERR  <= c_ERR_OK;
      cslRUN  <= 1'b0;
      cslHALT <= 1'b0;
      cslCONT <= 1'b0;
      cslEXEC <= 1'b0;
    end else begin
      cmdBUSY <= w_busy;
      cmdACK  <= w_ack;
      cmdERR  <= w_err;
      cslRUN  <= w_cslRun;
      cslHALT <= w_cslHalt;
      cslCONT <= w_cslCont;
      cslEXEC <= w_cslExec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cons_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cons_seq
// Description : Self-checking bench for cons_seq: a table of single-command
//               vectors plus hand-written EXEC, STEP, timeout and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cons_seq;

  import cons_seq_pkg::*;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       clken   = 1'b1;
  logic       cmdREQ  = 1'b0;
  logic [2:0] cmdCODE = 3'd0;
  logic       cpuRUN  = 1'b0;
  logic       cpuHALT = 1'b0;
  logic       cpuCONT = 1'b0;
  logic       cpuEXEC = 1'b0;
  logic       cmdBUSY, cmdACK;
  logic [1:0] cmdERR;
  logic       cslRUN, cslHALT, cslCONT, cslEXEC;

  always #5 clk = ~clk;

  cons_seq #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .cmdREQ  (cmdREQ),
    .cmdCODE (cmdCODE),
    .cmdBUSY (cmdBUSY),
    .cmdACK  (cmdACK),
    .cmdERR  (cmdERR),
    .cpuRUN  (cpuRUN),
    .cpuHALT (cpuHALT),
    .cpuCONT (cpuCONT),
    .cpuEXEC (cpuEXEC),
    .cslRUN  (cslRUN),
    .cslHALT (cslHALT),
    .cslCONT (cslCONT),
    .cslEXEC (cslEXEC)
  );

  int checks = 0;
  int errors = 0;

  int         ackCyc;
  int         ackCnt;
  int         cslCnt;
  int         multiHot;
  logic [3:0] cslMask;
  logic [1:0] errAtAck;
  logic [3:0] cslNow;

  assign cslNow = {cslEXEC, cslCONT, cslHALT, cslRUN};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearTrack();
    ackCyc   = -1;
    ackCnt   = 0;
    cslCnt   = 0;
    multiHot = 0;
    cslMask  = 4'b0000;
    errAtAck = 2'b00;
  endtask

  // Record observations for cycle k (called mid-cycle, away from the edge).
  task automatic sampleCycle(input int k);
    if (cmdACK) begin
      ackCnt++;
      if (ackCyc < 0) begin
        ackCyc   = k;
        errAtAck = cmdERR;
      end
    end
    if (cslNow != 4'b0000) cslCnt++;
    if ((cslNow & (cslNow - 4'd1)) != 4'b0000) multiHot++;
    cslMask = cslMask | cslNow;
  endtask

  typedef struct {
    logic [2:0] code;
    logic       run;
    logic       halt;
    logic [3:0] sw;     // {exec, cont, halt, run}
    int         ack;    // cycle of cmdACK, request in cycle 0
    logic [1:0] err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{c_CMD_NOP,  1'b0, 1'b0, 4'b0000, 2, c_ERR_OK};
    vecs[1] = '{3'd6,       1'b0, 1'b1, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[2] = '{3'd7,       1'b0, 1'b1, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[3] = '{c_CMD_CONT, 1'b0, 1'b0, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[4] = '{c_CMD_EXEC, 1'b1, 1'b0, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[5] = '{c_CMD_STEP, 1'b1, 1'b1, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[6] = '{c_CMD_STEP, 1'b0, 1'b0, 4'b0000, 2, c_ERR_ILLEGAL};
    vecs[7] = '{c_CMD_RUN,  1'b1, 1'b0, 4'b0001, 3, c_ERR_OK};
    vecs[8] = '{c_CMD_HALT, 1'b0, 1'b1, 4'b0010, 3, c_ERR_OK};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset busy", int'(cmdBUSY), 0);
    chk("reset ack",  int'(cmdACK), 0);
    chk("reset err",  int'(cmdERR), 0);
    chk("reset csl",  int'(cslNow), 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted while CONT is in ISSUE with clken held low.
    cpuRUN = 1'b0; cpuHALT = 1'b1; clken = 1'b0;
    cmdREQ = 1'b1; cmdCODE = c_CMD_CONT;
    @(negedge clk);
    cmdREQ = 1'b0;
    chk("issue cslCONT", int'(cslCONT), 1);
    chk("issue busy", int'(cmdBUSY), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst cslCONT", int'(cslCONT), 0);
    chk("rst busy", int'(cmdBUSY), 0);
    chk("rst ack", int'(cmdACK), 0);
    @(negedge clk);
    rst = 1'b1;
    clken = 1'b1;

    // Single-command vectors with static CPU flags and clken always high.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      cpuRUN = vecs[v].run; cpuHALT = vecs[v].halt;
      cpuCONT = 1'b0; cpuEXEC = 1'b0; clken = 1'b1;
      cmdREQ = 1'b1; cmdCODE = vecs[v].code;
      clearTrack();
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) begin
          cmdREQ = 1'b0;
          chk($sformatf("v%0d busy", v), int'(cmdBUSY), 1);
        end
        sampleCycle(k);
      end
      chk($sformatf("v%0d ackcyc", v), ackCyc, vecs[v].ack);
      chk($sformatf("v%0d ackcnt", v), ackCnt, 1);
      chk($sformatf("v%0d err", v), int'(errAtAck), int'(vecs[v].err));
      chk($sformatf("v%0d errheld", v), int'(cmdERR), int'(vecs[v].err));
      chk($sformatf("v%0d sw", v), int'(cslMask), int'(vecs[v].sw));
      chk($sformatf("v%0d swcnt", v), cslCnt, (vecs[v].sw != 4'b0000) ? 1 : 0);
      chk($sformatf("v%0d idle", v), int'(cmdBUSY), 0);
    end

    // EXEC with clken high one cycle in four; cmdCODE changes after accept.
    @(negedge clk);
    cpuRUN = 1'b0; cpuHALT = 1'b1; cpuCONT = 1'b0; cpuEXEC = 1'b0;
    clken = 1'b0; cmdREQ = 1'b1; cmdCODE = c_CMD_EXEC;
    clearTrack();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      sampleCycle(k);
      if (k == 9) chk("exec busy in wait", int'(cmdBUSY), 1);
      cmdREQ  = 1'b0;
      if (k == 2) cmdCODE = c_CMD_RUN;
      clken   = ((k % 4) == 3);
      cpuEXEC = (k >= 4) && (k <= 8);
    end
    chk("exec sw", int'(cslMask), 8);
    chk("exec swcnt", cslCnt, 3);
    chk("exec ackcyc", ackCyc, 10);
    chk("exec err", int'(errAtAck), int'(c_ERR_OK));
    clken = 1'b1;

    // STEP: cpuCONT pulses, cpuHALT drops for 3 cycles; a second request is ignored.
    @(negedge clk);
    cpuRUN = 1'b0; cpuHALT = 1'b1; cpuCONT = 1'b0; cpuEXEC = 1'b0;
    cmdREQ = 1'b1; cmdCODE = c_CMD_STEP;
    clearTrack();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sampleCycle(k);
      cmdREQ  = (k <= 3);
      cmdCODE = c_CMD_RUN;
      cpuCONT = (k == 2);
      cpuHALT = !((k >= 3) && (k <= 5));
    end
    chk("step sw", int'(cslMask), 4);
    chk("step swcnt", cslCnt, 1);
    chk("step ackcyc", ackCyc, 7);
    chk("step ackcnt", ackCnt, 1);
    chk("step err", int'(errAtAck), int'(c_ERR_OK));
    chk("step idle", int'(cmdBUSY), 0);
    chk("onehot", multiHot, 0);

`ifdef CONS_SEQ_TIMEOUT_EN
    // HALT that never completes times out after 16 WAIT cycles.
    @(negedge clk);
    cpuRUN = 1'b1; cpuHALT = 1'b0; cmdREQ = 1'b1; cmdCODE = c_CMD_HALT;
    clearTrack();
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      sampleCycle(k);
      cmdREQ = 1'b0;
    end
    chk("tmo ackcyc", ackCyc, 18);
    chk("tmo err", int'(errAtAck), int'(c_ERR_TIMEOUT));

    // Completion in the same cycle the timer expires: completion wins.
    @(negedge clk);
    cpuRUN = 1'b1; cpuHALT = 1'b0; cmdREQ = 1'b1; cmdCODE = c_CMD_HALT;
    clearTrack();
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      sampleCycle(k);
      cmdREQ = 1'b0;
      if (k == 17) begin
        cpuRUN = 1'b0; cpuHALT = 1'b1;
      end
    end
    chk("tie ackcyc", ackCyc, 18);
    chk("tie err", int'(errAtAck), int'(c_ERR_OK));
`else
    // Without the timer a never-completing HALT stays busy until reset.
    @(negedge clk);
    cpuRUN = 1'b1; cpuHALT = 1'b0; cmdREQ = 1'b1; cmdCODE = c_CMD_HALT;
    clearTrack();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sampleCycle(k);
      cmdREQ = 1'b0;
    end
    chk("notmo ack", ackCnt, 0);
    chk("notmo busy", int'(cmdBUSY), 1);
    rst = 1'b0;
    #1;
    chk("notmo rst busy", int'(cmdBUSY), 0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
